// File: rtl/prog_load_dump.sv
// rtl/prog_load_dump.sv - program load / run / DRAM dump sequencer
// Loads a framed image into IRAM, pulses the CPU, waits for idle, then streams DRAM out.
module prog_load_dump #(
    parameter int W_INSTR     = 16,
    parameter int IRAM_DEPTH  = 256,
    parameter int W_DATA      = 8,
    parameter int DRAM_DEPTH  = 256,
    parameter int RAM_LATENCY = 1,
    parameter int DUMP_LEN    = 256,
    parameter int TIMEOUT     = 0,
    localparam int BPW        = (W_INSTR + 7) / 8,
    localparam int W_IADDR    = $clog2(IRAM_DEPTH),
    localparam int W_DADDR    = $clog2(DRAM_DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               go,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [7:0]         m_data,
    output logic               iram_we,
    output logic [W_IADDR-1:0] iram_addr,
    output logic [W_INSTR-1:0] iram_din,
    output logic [W_DADDR-1:0] dram_addr,
    input  logic [W_DATA-1:0]  dram_dout,
    output logic               mem_own,
    output logic               start,
    input  logic               idle,
    output logic               busy,
    output logic               done,
    output logic               err_ovf,
    output logic               err_tmo
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_START, S_RUN, S_DWAIT, S_DOUT, S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_count;
    logic [15:0]          r_word_idx;
    logic [7:0]           r_byte_idx;
    logic [8*BPW-9:0]     r_asm;
    logic                 r_iram_we;
    logic [W_IADDR-1:0]   r_iram_addr;
    logic [W_INSTR-1:0]   r_iram_din;
    logic [31:0]          r_run_cnt;
    logic [W_DADDR-1:0]   r_dram_addr;
    logic [7:0]           r_lat;
    logic [7:0]           r_mdata;
    logic                 r_m_valid;
    logic                 r_err_ovf;
    logic                 r_err_tmo;

    logic                 w_s_fire;
    logic                 w_m_fire;
    logic [15:0]          w_hdr_n;
    logic [8*BPW-1:0]     w_asm;
    logic                 w_last_byte;
    logic                 w_last_word;
    logic                 w_idle_exit;
    logic                 w_tmo_hit;
    logic                 w_lat_done;
    logic                 w_last_addr;

    assign w_s_fire    = s_valid && s_ready;
    assign w_m_fire    = r_m_valid && m_ready;
    assign w_hdr_n     = {s_data, r_count[7:0]};
    // Bytes arrive LSB first: each new byte lands on top and older ones shift down.
    assign w_asm       = {s_data, r_asm};
    assign w_last_byte = (r_byte_idx == 8'(BPW - 1));
    assign w_last_word = ((r_word_idx + 16'd1) == r_count);
    // The CPU still reports idle on the first RUN cycle, so only trust it afterwards.
    assign w_idle_exit = idle && (r_run_cnt != 32'd0);
    assign w_tmo_hit   = (TIMEOUT > 0) && (r_run_cnt == 32'(TIMEOUT - 1)) && !w_idle_exit;
    assign w_lat_done  = (r_lat == 8'(RAM_LATENCY));
    assign w_last_addr = (r_dram_addr == W_DADDR'(DUMP_LEN - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (go) w_state_next = S_HDR0;
            S_HDR0:  if (w_s_fire) w_state_next = S_HDR1;
            S_HDR1:  if (w_s_fire) w_state_next = (w_hdr_n == 16'd0) ? S_START : S_LOAD;
            S_LOAD:  if (w_s_fire && w_last_byte && w_last_word) w_state_next = S_START;
            S_START: w_state_next = S_RUN;
            S_RUN:   if (w_idle_exit || w_tmo_hit) w_state_next = S_DWAIT;
            S_DWAIT: if (w_lat_done) w_state_next = S_DOUT;
            S_DOUT:  if (w_m_fire) w_state_next = w_last_addr ? S_DONE : S_DWAIT;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count     <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
            r_iram_we   <= 1'b0;
            r_iram_addr <= '0;
            r_iram_din  <= '0;
            r_run_cnt   <= '0;
            r_dram_addr <= '0;
            r_lat       <= '0;
            r_mdata     <= '0;
            r_m_valid   <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_iram_we <= 1'b0;
            case (r_state)
                S_IDLE: if (go) begin
                    r_err_ovf  <= 1'b0;
                    r_err_tmo  <= 1'b0;
                    r_count    <= '0;
                    r_word_idx <= '0;
                    r_byte_idx <= '0;
                end
                S_HDR0: if (w_s_fire) r_count[7:0] <= s_data;
                S_HDR1: if (w_s_fire) begin
                    r_count[15:8] <= s_data;
                    if (32'(w_hdr_n) > 32'(IRAM_DEPTH)) r_err_ovf <= 1'b1;
                end
                S_LOAD: if (w_s_fire) begin
                    r_asm <= w_asm[8*BPW-1:8];
                    if (w_last_byte) begin
                        r_byte_idx <= '0;
                        r_word_idx <= r_word_idx + 16'd1;
                        // Overflow words are swallowed; the address register is left alone.
                        if (32'(r_word_idx) < 32'(IRAM_DEPTH)) begin
                            r_iram_we   <= 1'b1;
                            r_iram_addr <= r_word_idx[W_IADDR-1:0];
                            r_iram_din  <= w_asm[W_INSTR-1:0];
                        end
                    end else begin
                        r_byte_idx <= r_byte_idx + 8'd1;
                    end
                end
                S_START: r_run_cnt <= '0;
                S_RUN: begin
                    if (r_run_cnt != '1) r_run_cnt <= r_run_cnt + 32'd1;
                    if (w_tmo_hit) r_err_tmo <= 1'b1;
                    if (w_idle_exit || w_tmo_hit) begin
                        r_dram_addr <= '0;
                        r_lat       <= '0;
                    end
                end
                S_DWAIT: begin
                    r_lat <= r_lat + 8'd1;
                    if (w_lat_done) begin
                        r_mdata   <= 8'(dram_dout);
                        r_m_valid <= 1'b1;
                    end
                end
                S_DOUT: if (w_m_fire) begin
                    r_m_valid <= 1'b0;
                    if (!w_last_addr) begin
                        r_dram_addr <= r_dram_addr + W_DADDR'(1);
                        r_lat       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_ready   = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_LOAD);
    assign m_valid   = r_m_valid;
    assign m_data    = r_mdata;
    assign iram_we   = r_iram_we;
    assign iram_addr = r_iram_addr;
    assign iram_din  = r_iram_din;
    assign dram_addr = r_dram_addr;
    // The final IRAM write lands in START, so ownership is held for that cycle too.
    assign mem_own   = (r_state == S_LOAD) || (r_state == S_DWAIT) || (r_state == S_DOUT) || r_iram_we;
    assign start     = (r_state == S_START);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err_ovf   = r_err_ovf;
    assign err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_prog_load_dump.sv
// tb/tb_prog_load_dump.sv - self-checking bench for prog_load_dump
// Two instances: defaults, and a 24-bit / depth-4 / latency-3 / timeout-50 variant.
module tb_prog_load_dump;
    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn    = 1'b0;
    logic       go      = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       m_ready = 1'b0;
    logic       idle    = 1'b1;
    int         sel     = 0;
    int         rmode   = 0;
    bit         gap_en  = 1'b0;
    bit         hang    = 1'b0;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    logic go0, go1;
    assign go0 = go && (sel == 0);
    assign go1 = go && (sel == 1);

    logic        s_ready0, m_valid0, iram_we0, mem_own0, start0, busy0, done0, ovf0, tmo0;
    logic [7:0]  m_data0, iram_addr0, dram_addr0, dram_dout0;
    logic [15:0] iram_din0;
    logic        s_ready1, m_valid1, iram_we1, mem_own1, start1, busy1, done1, ovf1, tmo1;
    logic [7:0]  m_data1, dram_addr1, dram_dout1;
    logic [1:0]  iram_addr1;
    logic [23:0] iram_din1;

    prog_load_dump u_dut0 (
        .clk(clk), .rstn(rstn), .go(go0), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
        .iram_we(iram_we0), .iram_addr(iram_addr0), .iram_din(iram_din0),
        .dram_addr(dram_addr0), .dram_dout(dram_dout0), .mem_own(mem_own0),
        .start(start0), .idle(idle), .busy(busy0), .done(done0), .err_ovf(ovf0), .err_tmo(tmo0)
    );

    prog_load_dump #(
        .W_INSTR(24), .IRAM_DEPTH(4), .W_DATA(8), .DRAM_DEPTH(256),
        .RAM_LATENCY(3), .DUMP_LEN(8), .TIMEOUT(50)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .go(go1), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
        .iram_we(iram_we1), .iram_addr(iram_addr1), .iram_din(iram_din1),
        .dram_addr(dram_addr1), .dram_dout(dram_dout1), .mem_own(mem_own1),
        .start(start1), .idle(idle), .busy(busy1), .done(done1), .err_ovf(ovf1), .err_tmo(tmo1)
    );

    logic        w_s_ready, w_m_valid, w_we, w_start, w_busy, w_done, w_ovf, w_tmo, w_own;
    logic [7:0]  w_m_data;
    logic [31:0] w_waddr;
    logic [23:0] w_wdata;
    assign w_s_ready = (sel == 1) ? s_ready1 : s_ready0;
    assign w_m_valid = (sel == 1) ? m_valid1 : m_valid0;
    assign w_m_data  = (sel == 1) ? m_data1  : m_data0;
    assign w_we      = (sel == 1) ? iram_we1 : iram_we0;
    assign w_waddr   = (sel == 1) ? 32'(iram_addr1) : 32'(iram_addr0);
    assign w_wdata   = (sel == 1) ? iram_din1 : 24'(iram_din0);
    assign w_start   = (sel == 1) ? start1 : start0;
    assign w_busy    = (sel == 1) ? busy1  : busy0;
    assign w_done    = (sel == 1) ? done1  : done0;
    assign w_ovf     = (sel == 1) ? ovf1   : ovf0;
    assign w_tmo     = (sel == 1) ? tmo1   : tmo0;
    assign w_own     = (sel == 1) ? mem_own1 : mem_own0;

    // Memories: IRAM write ports and DRAM read pipelines of latency 1 and 3.
    logic [15:0] iram0 [256];
    logic [23:0] iram1 [4];
    logic [7:0]  dram0 [256];
    logic [7:0]  dram1 [256];
    logic [7:0]  pipe1 [3];
    always @(posedge clk) begin
        if (iram_we0) iram0[iram_addr0] <= iram_din0;
        if (iram_we1) iram1[iram_addr1] <= iram_din1;
        dram_dout0 <= dram0[dram_addr0];
        pipe1[0]   <= dram1[dram_addr1];
        pipe1[1]   <= pipe1[0];
        pipe1[2]   <= pipe1[1];
    end
    assign dram_dout1 = pipe1[2];

    always @(posedge clk) cyc <= cyc + 1;

    // CPU: drops idle after start, raises it again after a random run unless hung.
    int cpu_left = 0;
    always @(negedge clk) begin
        if (w_start) begin
            idle     = 1'b0;
            cpu_left = $urandom_range(2, 30);
        end else if (!idle && !hang) begin
            if (cpu_left <= 1) idle = 1'b1;
            else cpu_left--;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int          wr_addr_q[$];
    logic [23:0] wr_data_q[$];
    logic [7:0]  out_q[$];
    int          start_cnt = 0, done_cnt = 0, start_cyc = 0, tmo_cyc = -1;
    logic        tmo_prev = 1'b0, stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (w_we) begin
                wr_addr_q.push_back(w_waddr);
                wr_data_q.push_back(w_wdata);
            end
            if (w_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (w_done) done_cnt++;
            if (w_tmo && !tmo_prev) tmo_cyc = cyc;
            tmo_prev = w_tmo;
            if (stall_prev) begin
                n_assert++;
                assert (w_m_valid === 1'b1 && w_m_data === stall_data) else begin
                    n_fail++;
                    $error("FAIL m_stall_hold: observed valid=%0b data=%0h expected valid=1 data=%0h",
                           w_m_valid, w_m_data, stall_data);
                end
            end
            if (w_m_valid && m_ready) out_q.push_back(w_m_data);
            stall_prev = w_m_valid && !m_ready;
            stall_data = w_m_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  budget;
        bit  got;
        if (gap_en) repeat ($urandom_range(0, 2)) tick();
        s_valid = 1'b1;
        s_data  = b;
        budget  = 0;
        got     = 1'b0;
        while (!got && budget < 1000) begin
            @(negedge clk);
            if (w_s_ready) got = 1'b1;
            budget++;
        end
        check("s_ready_wait", 32'(got), 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    function automatic byte_q_t make_frame(input int n, input int bpw);
        byte_q_t q;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < n * bpw; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic run_seq(input int which, input byte_q_t fr);
        int budget;
        sel = which;
        wr_addr_q.delete();
        wr_data_q.delete();
        out_q.delete();
        start_cnt = 0;
        done_cnt  = 0;
        tmo_cyc   = -1;
        go = 1'b1;
        tick();
        go = 1'b0;
        foreach (fr[i]) send_byte(fr[i]);
        go = 1'b1;
        tick();
        go = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 20000) begin
            tick();
            budget++;
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        tick();
        tick();
    endtask

    // Reference: words are little-endian groups of bpw payload bytes; only the
    // first min(N, depth) land in IRAM; the dump is DRAM[0..len-1] in order.
    task automatic verify(input int which, input byte_q_t fr, input logic exp_tmo);
        int          bpw, depth, dlen, n, nwr;
        logic [23:0] w;
        logic [23:0] got;
        bpw   = (which == 1) ? 3 : 2;
        depth = (which == 1) ? 4 : 256;
        dlen  = (which == 1) ? 8 : 256;
        n     = int'(fr[0]) + 256 * int'(fr[1]);
        nwr   = (n < depth) ? n : depth;
        check("write_count", 32'(wr_addr_q.size()), 32'(nwr));
        for (int i = 0; i < nwr && i < wr_addr_q.size(); i++) begin
            w = 24'd0;
            for (int k = 0; k < bpw; k++) w = w | (24'(fr[2 + i * bpw + k]) << (8 * k));
            if (which == 1) got = iram1[i];
            else got = 24'(iram0[i]);
            check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], 32'(i));
            check($sformatf("wr_data[%0d]", i), 32'(wr_data_q[i]), 32'(w));
            check($sformatf("iram[%0d]", i), 32'(got), 32'(w));
        end
        check("start_count", 32'(start_cnt), 32'd1);
        check("dump_len", 32'(out_q.size()), 32'(dlen));
        for (int i = 0; i < dlen && i < out_q.size(); i++) begin
            if (which == 1) check($sformatf("dump[%0d]", i), 32'(out_q[i]), 32'(dram1[i]));
            else check($sformatf("dump[%0d]", i), 32'(out_q[i]), 32'(dram0[i]));
        end
        check("err_ovf", 32'(w_ovf), 32'(n > depth));
        check("err_tmo", 32'(w_tmo), 32'(exp_tmo));
        if (exp_tmo) check("tmo_latency", 32'(tmo_cyc - start_cyc), 32'd51);
        check("busy_after", 32'(w_busy), 32'd0);
    endtask

    initial begin
        byte_q_t fr;
        for (int i = 0; i < 256; i++) begin
            dram0[i] = 8'($urandom);
            dram1[i] = 8'($urandom);
        end
        #3;
        check("reset_outs_dut0", {busy0, s_ready0, m_valid0, iram_we0, start0, done0, ovf0, tmo0, mem_own0}, 0);
        check("reset_outs_dut1", {busy1, s_ready1, m_valid1, iram_we1, start1, done1, ovf1, tmo1, mem_own1}, 0);
        check("reset_buses_dut0", {m_data0, iram_addr0, dram_addr0}, 0);
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        rmode = 0; gap_en = 1'b0; hang = 1'b0;
        fr = '{8'h03, 8'h00, 8'h01, 8'h10, 8'h02, 8'h20, 8'h00, 8'h00};
        run_seq(0, fr);
        verify(0, fr, 1'b0);
        check("kat_iram0_0", 32'(iram0[0]), 32'h1001);
        check("kat_iram0_1", 32'(iram0[1]), 32'h2002);
        check("kat_iram0_2", 32'(iram0[2]), 32'h0000);

        rmode = 1; gap_en = 1'b1;
        fr = make_frame($urandom_range(1, 12), 2);
        run_seq(0, fr);
        verify(0, fr, 1'b0);

        rmode = 2; hang = 1'b1;
        fr = make_frame(6, 3);
        run_seq(1, fr);
        verify(1, fr, 1'b1);
        hang = 1'b0;

        fr = make_frame(2, 3);
        run_seq(1, fr);
        verify(1, fr, 1'b0);

        rmode = 0; gap_en = 1'b0; sel = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        tick();
        check("busy_mid_load", 32'(w_busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("reset_mid_outs", {w_busy, w_s_ready, w_m_valid, w_we, w_start, w_done, w_own, w_ovf, w_tmo}, 0);
        check("iram_kept", 32'(iram0[0]), 32'h2211);
        tick();
        rstn = 1'b1;
        tick();
        gap_en = 1'b1;
        fr = make_frame(3, 2);
        run_seq(0, fr);
        verify(0, fr, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
